// File: rtl/regfile_arb.sv
// regfile_arb: two-master round-robin sequencer in front of a single-port regfile.
// Each master issues one access via a req/ack handshake. The winner's wr/addr/wdata
// drive the regfile. Read data is registered into that master's rdata, and the
// master gets a one-cycle ack.
//   clk, reset_           rising-edge clock, asynchronous active-low reset
//   mX_req/wr/addr/wdata  master request; held stable until mX_ack
//   mX_ack                one-cycle completion pulse
//   mX_rdata              read data, held until that master's next read ack
//   rf_we_/addr/din       regfile write strobe (active-low), address, write data
//   rf_dout               regfile read data (READ_LAT cycles after rf_addr)
//   busy                  high whenever the sequencer is not idle
module regfile_arb #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 0
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              rf_we_,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_last_gnt, w_last_gnt_nxt;  // 0 = M0, 1 = M1
  logic                r_gnt, w_gnt_nxt;
  logic                r_wr, w_wr_nxt;
  logic                r_we_n, w_we_n_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_din, w_din_nxt;
  logic                r_m0_ack, w_m0_ack_nxt;
  logic                r_m1_ack, w_m1_ack_nxt;
  logic [DATA_W-1:0]   r_m0_rdata, w_m0_rdata_nxt;
  logic [DATA_W-1:0]   r_m1_rdata, w_m1_rdata_nxt;
  logic                r_busy, w_busy_nxt;

  // Arbitration: a lone requester wins; on a tie the master that was not granted last wins
  logic                w_pick;
  logic                w_pick_wr;
  logic [ADDR_W-1:0]   w_pick_addr;
  logic [DATA_W-1:0]   w_pick_wdata;

  assign w_pick       = (m0_req && m1_req) ? ~r_last_gnt : m1_req;
  assign w_pick_wr    = w_pick ? m1_wr    : m0_wr;
  assign w_pick_addr  = w_pick ? m1_addr  : m0_addr;
  assign w_pick_wdata = w_pick ? m1_wdata : m0_wdata;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_last_gnt_nxt = r_last_gnt;
    w_gnt_nxt      = r_gnt;
    w_wr_nxt       = r_wr;
    w_we_n_nxt     = 1'b1;
    w_addr_nxt     = r_addr;
    w_din_nxt      = r_din;
    w_m0_ack_nxt   = 1'b0;
    w_m1_ack_nxt   = 1'b0;
    w_m0_rdata_nxt = r_m0_rdata;
    w_m1_rdata_nxt = r_m1_rdata;

    case (r_state)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          w_gnt_nxt      = w_pick;
          w_last_gnt_nxt = w_pick;
          w_wr_nxt       = w_pick_wr;
          w_addr_nxt     = w_pick_addr;
          w_din_nxt      = w_pick_wdata;
          w_we_n_nxt     = ~w_pick_wr;
          w_state_nxt    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_wr || (READ_LAT == 0)) begin
          // A zero-latency read has valid rf_dout during ACCESS itself
          if (!r_wr) begin
            if (r_gnt) w_m1_rdata_nxt = rf_dout;
            else       w_m0_rdata_nxt = rf_dout;
          end
          w_m0_ack_nxt = ~r_gnt;
          w_m1_ack_nxt = r_gnt;
          w_state_nxt  = S_ACK;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_gnt) w_m1_rdata_nxt = rf_dout;
        else       w_m0_rdata_nxt = rf_dout;
        w_m0_ack_nxt = ~r_gnt;
        w_m1_ack_nxt = r_gnt;
        w_state_nxt  = S_ACK;
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
      r_gnt      <= 1'b0;
      r_wr       <= 1'b0;
      r_we_n     <= 1'b1;
      r_addr     <= '0;
      r_din      <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_wr       <= w_wr_nxt;
      r_we_n     <= w_we_n_nxt;
      r_addr     <= w_addr_nxt;
      r_din      <= w_din_nxt;
      r_m0_ack   <= w_m0_ack_nxt;
      r_m1_ack   <= w_m1_ack_nxt;
      r_m0_rdata <= w_m0_rdata_nxt;
      r_m1_rdata <= w_m1_rdata_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign rf_we_   = r_we_n;
  assign rf_addr  = r_addr;
  assign rf_din   = r_din;
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;
  assign busy     = r_busy;

endmodule

// File: tb/tb_regfile_arb.sv
// Bench for regfile_arb: behavioural regfile, two master drivers, scoreboard of expected acks.
module tb_regfile_arb;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned RL    = 0;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic          m;
    logic          wr;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          rf_we_;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_din, rf_dout;
  logic          busy;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_acks  = 0;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;
  logic [DW-1:0] rf_mem  [DEPTH];

  always #5 clk = ~clk;

  regfile_arb #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
    .clk(clk), .reset_(reset_),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .rf_we_(rf_we_), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout),
    .busy(busy)
  );

  // Behavioural single-port regfile
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < int'(DEPTH); i++) rf_mem[i] <= '0;
    end else if (!rf_we_) begin
      rf_mem[rf_addr] <= rf_din;
    end
  end

  if (RL == 0) begin : g_rd_comb
    assign rf_dout = rf_mem[rf_addr];
  end else begin : g_rd_reg
    logic [DW-1:0] dout_q;
    always @(posedge clk) dout_q <= rf_mem[rf_addr];
    assign rf_dout = dout_q;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic m, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_t e;
    e.m  = m;
    e.wr = wr;
    if (wr) begin
      e.d        = d;
      ref_mem[a] = d;
    end else begin
      e.d = ref_mem[a];
    end
    sb.push_back(e);
  endtask

  // One access from master m; lat counts edges from the first sampling edge to the ack
  task automatic m_access(input logic m, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
    int  k;
    bit  seen;
    if (m) begin
      m1_req = 1'b1; m1_wr = wr; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = 1'b1; m0_wr = wr; m0_addr = a; m0_wdata = d;
    end
    seen = 1'b0;
    lat  = 0;
    k    = 0;
    while (!seen && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (m ? m1_ack : m0_ack) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk("ack_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    if (m) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  // Every ack must match the head of the scoreboard; both rdata ports are checked each time
  always @(negedge clk) begin
    if (!reset_) begin
      exp_rd0 = '0;
      exp_rd1 = '0;
    end else if (m0_ack || m1_ack) begin
      n_acks++;
      chk("single_ack", 32'(m0_ack & m1_ack), 32'd0);
      chk("ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("ack_master", 32'(m1_ack), 32'(mon_e.m));
        if (!mon_e.wr) begin
          if (mon_e.m) exp_rd1 = mon_e.d;
          else         exp_rd0 = mon_e.d;
        end
      end
      chk("m0_rdata", 32'(m0_rdata), 32'(exp_rd0));
      chk("m1_rdata", 32'(m1_rdata), 32'(exp_rd1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks_before;
    reset_ = 1'b0;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;

    // Reset values while reset_ is held low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    32'(rf_we_),   32'd1);
    chk("rst_addr",  32'(rf_addr),  32'd0);
    chk("rst_ack0",  32'(m0_ack),   32'd0);
    chk("rst_ack1",  32'(m1_ack),   32'd0);
    chk("rst_rd0",   32'(m0_rdata), 32'd0);
    chk("rst_rd1",   32'(m1_rdata), 32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    reset_ = 1'b1;
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a write: strobe released at once, no ack
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 4'd7; m0_wdata = 8'h77;
    @(posedge clk); #1;
    chk("abort_we_low",  32'(rf_we_), 32'd0);
    acks_before = n_acks;
    #2 reset_ = 1'b0;
    #1;
    chk("abort_we_high", 32'(rf_we_), 32'd1);
    chk("abort_busy",    32'(busy),   32'd0);
    m0_req = 1'b0;
    @(posedge clk); #1;
    reset_ = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_ack", 32'(n_acks), 32'(acks_before));

    // Timed M0 write addr 3 = 0x5A
    push_exp(1'b0, 1'b1, 4'd3, 8'h5A);
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 4'd3; m0_wdata = 8'h5A;
    @(negedge clk);
    chk("t2_we_c0",   32'(rf_we_),  32'd1);
    @(negedge clk);
    chk("t2_we_c1",   32'(rf_we_),  32'd0);
    chk("t2_addr_c1", 32'(rf_addr), 32'd3);
    chk("t2_din_c1",  32'(rf_din),  32'h5A);
    chk("t2_busy_c1", 32'(busy),    32'd1);
    chk("t2_ack_c1",  32'(m0_ack),  32'd0);
    @(negedge clk);
    chk("t2_we_c2",   32'(rf_we_),  32'd1);
    chk("t2_ack_c2",  32'(m0_ack),  32'd1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(posedge clk); #1;
    chk("t2_ack_c3",  32'(m0_ack),  32'd0);
    chk("t2_busy_c3", 32'(busy),    32'd0);

    // M1 reads back addr 3; M0 rdata untouched
    push_exp(1'b1, 1'b0, 4'd3, '0);
    m_access(1'b1, 1'b0, 4'd3, '0, lat);
    chk("t3_lat",      32'(lat),      32'(2 + RL));
    chk("t3_m1_rdata", 32'(m1_rdata), 32'h5A);
    chk("t3_m0_rdata", 32'(m0_rdata), 32'd0);

    // Both masters requesting continuously from reset: grants alternate M0, M1, ...
    do_reset();
    for (int i = 0; i < int'(DEPTH) / 2; i++) begin
      push_exp(1'b0, 1'b1, AW'(2 * i),     DW'(2 * i + 1));
      push_exp(1'b1, 1'b1, AW'(2 * i + 1), DW'(2 * i + 2));
    end
    fork
      begin : t4_m0
        int l;
        for (int i = 0; i < int'(DEPTH) / 2; i++)
          m_access(1'b0, 1'b1, AW'(2 * i), DW'(2 * i + 1), l);
      end
      begin : t4_m1
        int l;
        for (int i = 0; i < int'(DEPTH) / 2; i++)
          m_access(1'b1, 1'b1, AW'(2 * i + 1), DW'(2 * i + 2), l);
      end
    join
    for (int a = 0; a < int'(DEPTH); a++) begin
      push_exp(1'b0, 1'b0, AW'(a), '0);
      m_access(1'b0, 1'b0, AW'(a), '0, lat);
    end
    chk("t4_last_rd", 32'(m0_rdata), 32'(DEPTH));

    // M0 holds req across three accesses; M1 requests once mid-way and wins the next idle
    push_exp(1'b0, 1'b1, 4'd8,  8'hA1);
    push_exp(1'b1, 1'b1, 4'd9,  8'hB1);
    push_exp(1'b0, 1'b1, 4'd10, 8'hA2);
    push_exp(1'b0, 1'b1, 4'd11, 8'hA3);
    fork
      begin : t5_m0
        int l;
        m_access(1'b0, 1'b1, 4'd8,  8'hA1, l);
        m_access(1'b0, 1'b1, 4'd10, 8'hA2, l);
        m_access(1'b0, 1'b1, 4'd11, 8'hA3, l);
      end
      begin : t5_m1
        int l;
        @(posedge clk); #1;
        m_access(1'b1, 1'b1, 4'd9, 8'hB1, l);
      end
    join

    // Lone M1 read leaves last grant on M1, so M0 wins the following tie
    push_exp(1'b1, 1'b0, 4'd9, '0);
    m_access(1'b1, 1'b0, 4'd9, '0, lat);
    chk("t5_m1_rd9", 32'(m1_rdata), 32'hB1);

    // Simultaneous writes to one address: M0 then M1, so M1's data survives
    push_exp(1'b0, 1'b1, 4'd5, 8'h11);
    push_exp(1'b1, 1'b1, 4'd5, 8'h22);
    fork
      begin : t6_m0
        int l;
        m_access(1'b0, 1'b1, 4'd5, 8'h11, l);
      end
      begin : t6_m1
        int l;
        m_access(1'b1, 1'b1, 4'd5, 8'h22, l);
      end
    join
    push_exp(1'b0, 1'b0, 4'd5, '0);
    m_access(1'b0, 1'b0, 4'd5, '0, lat);
    chk("t6_final", 32'(m0_rdata), 32'h22);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
